// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [XLEN-1:0] zext_addr(input logic [REG_ADDR_W-1:0] a);
        return {{(XLEN-REG_ADDR_W){1'b0}}, a};
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its ALU/LSU/issue/regfile neighbours.
// Optional RF_WB_PERF_EN adds the ALU-conflict counter signal.
interface regfile_wb_arbiter_if #(
    parameter int STARVE_LIMIT = 8
);
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_addr;
    logic [31:0] alu_wb_data;
    logic        lsu_wb_valid;
    logic        lsu_wb_ready;
    logic [4:0]  lsu_wb_addr;
    logic [31:0] lsu_wb_data;
    logic        issue_valid;
    logic        issue_is_load;
    logic [4:0]  issue_rs1_addr;
    logic [4:0]  issue_rs2_addr;
    logic [4:0]  issue_rd_addr;
    logic        issue_stall;
    logic        RegWrite;
    logic [31:0] w_reg_addr;
    logic [31:0] w_data;
`ifdef RF_WB_PERF_EN
    logic [STARVE_LIMIT-1:0] alu_conflict_cnt;
`endif

    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        input  lsu_wb_ready,
        output issue_valid, issue_is_load, issue_rs1_addr, issue_rs2_addr, issue_rd_addr,
        input  issue_stall,
        input  RegWrite, w_reg_addr, w_data
`ifdef RF_WB_PERF_EN
        , input alu_conflict_cnt
`endif
    );

    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        output lsu_wb_ready,
        input  issue_valid, issue_is_load, issue_rs1_addr, issue_rs2_addr, issue_rd_addr,
        output issue_stall,
        output RegWrite, w_reg_addr, w_data
`ifdef RF_WB_PERF_EN
        , output alu_conflict_cnt
`endif
    );

endinterface

// File: rtl/wb_fifo.sv
// Load-return buffer: power-of-two depth circular FIFO with registered count.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wb_req_t                    push_data,
    input  logic                       pop,
    output wb_req_t                    pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{addr: 5'd0, data: 32'd0};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU has priority, load returns buffered and drained
// on ALU-idle cycles, load scoreboard stalls issue. Optional RF_WB_PERF_EN conflict counter.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_wb_arbiter_if.slave    bus
);
    localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;

    logic                   fifo_push_s;
    logic                   fifo_pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   fifo_has_head_s;
    logic [CNT_W-1:0]       fifo_count_s;
    wb_req_t                lsu_req_s;
    wb_req_t                fifo_head_s;

    logic                   we_nxt_s;
    logic                   is_load_nxt_s;
    logic                   sel_nxt_s;
    wb_req_t                wb_nxt_s;

    logic                   reg_write_r;
    logic                   wb_is_load_r;
    logic [REG_ADDR_W-1:0]  w_addr_r;
    logic [XLEN-1:0]        w_data_r;

    logic [NUM_REGS-1:0]    pending_r;
    logic [NUM_REGS-1:0]    pending_nxt_s;
    logic                   issue_stall_s;
    logic                   issue_fire_s;

    function automatic logic reg_busy(input logic [NUM_REGS-1:0] pend,
                                      input logic [REG_ADDR_W-1:0] a);
        return (a != ZERO_REG) && pend[a];
    endfunction

    assign lsu_req_s       = '{addr: bus.lsu_wb_addr, data: bus.lsu_wb_data};
    assign bus.lsu_wb_ready = !fifo_full_s;
    assign fifo_push_s     = bus.lsu_wb_valid && !fifo_full_s;
    assign fifo_has_head_s = !fifo_empty_s && (fifo_count_s != {CNT_W{1'b0}});
    assign fifo_pop_s      = !bus.alu_wb_valid && fifo_has_head_s;

    wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (lsu_req_s),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Port grant: ALU first, otherwise the FIFO head; x0 targets are consumed silently.
    always_comb begin
        we_nxt_s      = 1'b0;
        is_load_nxt_s = 1'b0;
        sel_nxt_s     = 1'b0;
        wb_nxt_s      = '{addr: w_addr_r, data: w_data_r};
        if (bus.alu_wb_valid) begin
            sel_nxt_s = 1'b1;
            wb_nxt_s  = '{addr: bus.alu_wb_addr, data: bus.alu_wb_data};
            we_nxt_s  = (bus.alu_wb_addr != ZERO_REG);
        end else if (fifo_pop_s) begin
            sel_nxt_s     = 1'b1;
            wb_nxt_s      = fifo_head_s;
            we_nxt_s      = (fifo_head_s.addr != ZERO_REG);
            is_load_nxt_s = 1'b1;
        end else begin
            sel_nxt_s = 1'b0;
        end
    end

    // Registered write stage driving the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_r  <= 1'b0;
            wb_is_load_r <= 1'b0;
            w_addr_r     <= ZERO_REG;
            w_data_r     <= 32'd0;
        end else begin
            reg_write_r  <= we_nxt_s;
            wb_is_load_r <= is_load_nxt_s;
            if (sel_nxt_s) begin
                w_addr_r <= wb_nxt_s.addr;
                w_data_r <= wb_nxt_s.data;
            end
        end
    end

    // Hazard check against outstanding loads; x0 is never considered busy.
    always_comb begin
        issue_stall_s = 1'b0;
        if (bus.issue_valid) begin
            issue_stall_s = reg_busy(pending_r, bus.issue_rs1_addr) ||
                            reg_busy(pending_r, bus.issue_rs2_addr) ||
                            reg_busy(pending_r, bus.issue_rd_addr);
        end else begin
            issue_stall_s = 1'b0;
        end
        issue_fire_s = bus.issue_valid && bus.issue_is_load && !issue_stall_s &&
                       (bus.issue_rd_addr != ZERO_REG);
    end

    // Scoreboard update: clear on the load's register-file write, then set so a new load wins.
    always_comb begin
        pending_nxt_s = pending_r;
        if (reg_write_r && wb_is_load_r) begin
            pending_nxt_s[w_addr_r] = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (issue_fire_s) begin
            pending_nxt_s[bus.issue_rd_addr] = 1'b1;
        end else begin
            pending_nxt_s[0] = pending_nxt_s[0];
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign bus.issue_stall = issue_stall_s;
    assign bus.RegWrite    = reg_write_r;
    assign bus.w_reg_addr  = zext_addr(w_addr_r);
    assign bus.w_data      = w_data_r;

`ifdef RF_WB_PERF_EN
    logic [STARVE_LIMIT-1:0] conflict_cnt_r;

    // Saturating count of cycles where a buffered load lost the port to the ALU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt_r <= {STARVE_LIMIT{1'b0}};
        end else if (bus.alu_wb_valid && fifo_has_head_s &&
                     (conflict_cnt_r != {STARVE_LIMIT{1'b1}})) begin
            conflict_cnt_r <= conflict_cnt_r + STARVE_LIMIT'(1);
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign bus.alu_conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model. Checks the conflict counter when RF_WB_PERF_EN is set.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 2;
    localparam int SL    = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    regfile_wb_arbiter_if #(.STARVE_LIMIT(SL)) bus ();

    regfile_wb_arbiter #(.LSU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    wb_req_t     m_q[$];
    logic [31:0] m_pending;
    logic        m_rw;
    logic        m_isload;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_cnt;

    task automatic model_reset();
        m_q.delete();
        m_pending = 32'd0;
        m_rw      = 1'b0;
        m_isload  = 1'b0;
        m_waddr   = 5'd0;
        m_wdata   = 32'd0;
        m_cnt     = 0;
    endtask

    function automatic logic m_ready();
        return m_q.size() < DEPTH;
    endfunction

    function automatic logic m_stall();
        logic s;
        s = 1'b0;
        if (bus.issue_valid) begin
            if (bus.issue_rs1_addr != 5'd0 && m_pending[bus.issue_rs1_addr]) s = 1'b1;
            if (bus.issue_rs2_addr != 5'd0 && m_pending[bus.issue_rs2_addr]) s = 1'b1;
            if (bus.issue_rd_addr  != 5'd0 && m_pending[bus.issue_rd_addr])  s = 1'b1;
        end
        return s;
    endfunction

    task automatic idle_inputs();
        bus.alu_wb_valid   = 1'b0;
        bus.alu_wb_addr    = 5'd0;
        bus.alu_wb_data    = 32'd0;
        bus.lsu_wb_valid   = 1'b0;
        bus.lsu_wb_addr    = 5'd0;
        bus.lsu_wb_data    = 32'd0;
        bus.issue_valid    = 1'b0;
        bus.issue_is_load  = 1'b0;
        bus.issue_rs1_addr = 5'd0;
        bus.issue_rs2_addr = 5'd0;
        bus.issue_rd_addr  = 5'd0;
    endtask

    // Advance one clock, updating the model from the inputs presented in this cycle.
    task automatic step();
        wb_req_t     e;
        int          sz;
        logic        rdy, stl, n_rw, n_ld;
        logic [4:0]  n_a;
        logic [31:0] n_d;
        sz   = m_q.size();
        rdy  = m_ready();
        stl  = m_stall();
        n_rw = 1'b0;
        n_ld = 1'b0;
        n_a  = m_waddr;
        n_d  = m_wdata;
        if (bus.alu_wb_valid) begin
            n_rw = (bus.alu_wb_addr != 5'd0);
            n_a  = bus.alu_wb_addr;
            n_d  = bus.alu_wb_data;
        end else if (sz > 0) begin
            e    = m_q.pop_front();
            n_rw = (e.addr != 5'd0);
            n_a  = e.addr;
            n_d  = e.data;
            n_ld = 1'b1;
        end
        if (bus.lsu_wb_valid && rdy) m_q.push_back('{addr: bus.lsu_wb_addr, data: bus.lsu_wb_data});
        if (bus.alu_wb_valid && sz > 0 && m_cnt < (1 << SL) - 1) m_cnt++;
        if (m_rw && m_isload) m_pending[m_waddr] = 1'b0;
        if (bus.issue_valid && bus.issue_is_load && !stl && bus.issue_rd_addr != 5'd0)
            m_pending[bus.issue_rd_addr] = 1'b1;
        @(posedge clk);
        #1;
        m_rw     = n_rw;
        m_isload = n_ld;
        m_waddr  = n_a;
        m_wdata  = n_d;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        bus.issue_valid    = 1'b1;
        bus.issue_rs1_addr = 5'd9;
        #12;
        n_cmp++; if (bus.RegWrite !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus.RegWrite); end
        n_cmp++; if (bus.w_reg_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.w_reg_addr); end
        n_cmp++; if (bus.w_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.w_data); end
        n_cmp++; if (bus.issue_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.issue_stall); end
        reset = 1'b1;
        idle_inputs();
        #1;
        n_cmp++; if (bus.lsu_wb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.lsu_wb_ready); end
        step();
    endtask

    task automatic test_alu_only();
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_addr  = 5'd5;
        bus.alu_wb_data  = 32'hDEADBEEF;
        step();
        idle_inputs();
        n_cmp++; if (bus.RegWrite !== 1'b1) begin n_bad++; $display("FAIL alu_we: got %b want 1", bus.RegWrite); end
        n_cmp++; if (bus.w_reg_addr !== 32'd5) begin n_bad++; $display("FAIL alu_addr: got %h want 5", bus.w_reg_addr); end
        n_cmp++; if (bus.w_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_data: got %h want deadbeef", bus.w_data); end
        step();
        n_cmp++; if (bus.RegWrite !== 1'b0) begin n_bad++; $display("FAIL alu_idle_we: got %b want 0", bus.RegWrite); end
    endtask

    task automatic test_conflict();
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd3; bus.alu_wb_data = 32'h11;
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd4; bus.lsu_wb_data = 32'h22;
        step();
        idle_inputs();
        n_cmp++; if (bus.RegWrite !== 1'b1 || bus.w_reg_addr !== 32'd3 || bus.w_data !== 32'h11) begin
            n_bad++; $display("FAIL conflict_alu: got we=%b a=%0d d=%h want we=1 a=3 d=11", bus.RegWrite, bus.w_reg_addr, bus.w_data); end
        step();
        n_cmp++; if (bus.RegWrite !== 1'b1 || bus.w_reg_addr !== 32'd4 || bus.w_data !== 32'h22) begin
            n_bad++; $display("FAIL conflict_lsu: got we=%b a=%0d d=%h want we=1 a=4 d=22", bus.RegWrite, bus.w_reg_addr, bus.w_data); end
        step();
    endtask

    task automatic test_full_fifo();
        logic [31:0] da, db;
        da = $urandom();
        db = $urandom();
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd1; bus.alu_wb_data = $urandom();
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd10; bus.lsu_wb_data = da;
        step();
        bus.alu_wb_addr = 5'd2; bus.alu_wb_data = $urandom();
        bus.lsu_wb_addr = 5'd11; bus.lsu_wb_data = db;
        #1;
        n_cmp++; if (bus.lsu_wb_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_one: got %b want 1", bus.lsu_wb_ready); end
        step();
        bus.alu_wb_addr = 5'd3; bus.alu_wb_data = $urandom();
        bus.lsu_wb_addr = 5'd12; bus.lsu_wb_data = $urandom();
        #1;
        n_cmp++; if (bus.lsu_wb_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_two: got %b want 0", bus.lsu_wb_ready); end
        step();
        idle_inputs();
        #1;
        n_cmp++; if (bus.lsu_wb_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_hold: got %b want 0", bus.lsu_wb_ready); end
        step();
        n_cmp++; if (bus.RegWrite !== 1'b1 || bus.w_reg_addr !== 32'd10 || bus.w_data !== da) begin
            n_bad++; $display("FAIL full_drain_first: got we=%b a=%0d d=%h want a=10 d=%h", bus.RegWrite, bus.w_reg_addr, bus.w_data, da); end
        n_cmp++; if (bus.lsu_wb_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_back: got %b want 1", bus.lsu_wb_ready); end
        step();
        n_cmp++; if (bus.RegWrite !== 1'b1 || bus.w_reg_addr !== 32'd11 || bus.w_data !== db) begin
            n_bad++; $display("FAIL full_drain_second: got we=%b a=%0d d=%h want a=11 d=%h", bus.RegWrite, bus.w_reg_addr, bus.w_data, db); end
        step();
        n_cmp++; if (bus.RegWrite !== 1'b0) begin n_bad++; $display("FAIL full_no_stale: got %b want 0", bus.RegWrite); end
    endtask

    task automatic test_scoreboard();
        bus.issue_valid = 1'b1; bus.issue_is_load = 1'b1; bus.issue_rd_addr = 5'd7;
        #1;
        n_cmp++; if (bus.issue_stall !== 1'b0) begin n_bad++; $display("FAIL sb_load_issue: got %b want 0", bus.issue_stall); end
        step();
        bus.issue_is_load = 1'b0; bus.issue_rd_addr = 5'd1; bus.issue_rs1_addr = 5'd7;
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd7; bus.lsu_wb_data = 32'h0000_7777;
        #1;
        n_cmp++; if (bus.issue_stall !== 1'b1) begin n_bad++; $display("FAIL sb_stall_pend: got %b want 1", bus.issue_stall); end
        step();
        bus.lsu_wb_valid = 1'b0;
        #1;
        n_cmp++; if (bus.issue_stall !== 1'b1) begin n_bad++; $display("FAIL sb_stall_buf: got %b want 1", bus.issue_stall); end
        step();
        n_cmp++; if (bus.RegWrite !== 1'b1 || bus.w_reg_addr !== 32'd7) begin
            n_bad++; $display("FAIL sb_load_write: got we=%b a=%0d want we=1 a=7", bus.RegWrite, bus.w_reg_addr); end
        n_cmp++; if (bus.issue_stall !== 1'b1) begin n_bad++; $display("FAIL sb_stall_wcycle: got %b want 1", bus.issue_stall); end
        step();
        n_cmp++; if (bus.issue_stall !== 1'b0) begin n_bad++; $display("FAIL sb_stall_release: got %b want 0", bus.issue_stall); end
        step();
        idle_inputs();
    endtask

    task automatic test_x0();
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd0; bus.alu_wb_data = 32'h55;
        step();
        bus.alu_wb_valid = 1'b0;
        n_cmp++; if (bus.RegWrite !== 1'b0) begin n_bad++; $display("FAIL x0_alu_we: got %b want 0", bus.RegWrite); end
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd0; bus.lsu_wb_data = 32'h66;
        bus.issue_valid = 1'b1; bus.issue_is_load = 1'b1; bus.issue_rd_addr = 5'd0;
        step();
        bus.lsu_wb_addr = 5'd6; bus.lsu_wb_data = 32'h77;
        bus.issue_is_load = 1'b0;
        #1;
        n_cmp++; if (bus.issue_stall !== 1'b0) begin n_bad++; $display("FAIL x0_no_pend: got %b want 0", bus.issue_stall); end
        step();
        idle_inputs();
        n_cmp++; if (bus.RegWrite !== 1'b0) begin n_bad++; $display("FAIL x0_lsu_we: got %b want 0", bus.RegWrite); end
        step();
        n_cmp++; if (bus.RegWrite !== 1'b1 || bus.w_reg_addr !== 32'd6 || bus.w_data !== 32'h77) begin
            n_bad++; $display("FAIL x0_drain_next: got we=%b a=%0d d=%h want we=1 a=6 d=77", bus.RegWrite, bus.w_reg_addr, bus.w_data); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.issue_valid = 1'b1; bus.issue_is_load = 1'b1; bus.issue_rd_addr = 5'd9;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd2; bus.alu_wb_data = 32'h1;
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd12; bus.lsu_wb_data = 32'hC;
        step();
        bus.issue_valid = 1'b0;
        bus.lsu_wb_addr = 5'd13; bus.lsu_wb_data = 32'hD;
        step();
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        bus.issue_valid = 1'b1; bus.issue_rs1_addr = 5'd9;
        #1;
        n_cmp++; if (bus.RegWrite !== 1'b0 || bus.w_reg_addr !== 32'd0 || bus.w_data !== 32'd0) begin
            n_bad++; $display("FAIL rstmid_out: got we=%b a=%h d=%h want all 0", bus.RegWrite, bus.w_reg_addr, bus.w_data); end
        n_cmp++; if (bus.issue_stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_pend: got %b want 0", bus.issue_stall); end
        idle_inputs();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (bus.lsu_wb_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", bus.lsu_wb_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (bus.RegWrite !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale: cycle %0d got %b want 0", k, bus.RegWrite); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.alu_wb_valid   = ($urandom_range(0, 99) < 40);
            bus.alu_wb_addr    = 5'($urandom_range(0, 7));
            bus.alu_wb_data    = $urandom();
            bus.lsu_wb_valid   = ($urandom_range(0, 99) < 50);
            bus.lsu_wb_addr    = 5'($urandom_range(0, 7));
            bus.lsu_wb_data    = $urandom();
            bus.issue_valid    = ($urandom_range(0, 99) < 50);
            bus.issue_is_load  = ($urandom_range(0, 99) < 40);
            bus.issue_rs1_addr = 5'($urandom_range(0, 7));
            bus.issue_rs2_addr = 5'($urandom_range(0, 7));
            bus.issue_rd_addr  = 5'($urandom_range(0, 7));
            #1;
            n_cmp++; if (bus.lsu_wb_ready !== m_ready()) begin n_bad++;
                $display("FAIL rnd_ready: cycle %0d got %b want %b", c, bus.lsu_wb_ready, m_ready()); end
            n_cmp++; if (bus.issue_stall !== m_stall()) begin n_bad++;
                $display("FAIL rnd_stall: cycle %0d got %b want %b", c, bus.issue_stall, m_stall()); end
            step();
            n_cmp++; if (bus.RegWrite !== m_rw) begin n_bad++;
                $display("FAIL rnd_we: cycle %0d got %b want %b", c, bus.RegWrite, m_rw); end
            n_cmp++; if (bus.w_reg_addr !== {27'd0, m_waddr} || bus.w_data !== m_wdata) begin n_bad++;
                $display("FAIL rnd_wb: cycle %0d got a=%0d d=%h want a=%0d d=%h", c, bus.w_reg_addr, bus.w_data, m_waddr, m_wdata); end
`ifdef RF_WB_PERF_EN
            n_cmp++; if (bus.alu_conflict_cnt !== SL'(m_cnt)) begin n_bad++;
                $display("FAIL rnd_perf: cycle %0d got %0d want %0d", c, bus.alu_conflict_cnt, m_cnt); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_only();
        test_conflict();
        test_full_fifo();
        test_scoreboard();
        test_x0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between the ALU writeback path and the load/store unit's load-return path.
- The ALU has fixed priority. Load returns are buffered in a small FIFO and drain on ALU-idle cycles.
- A load scoreboard stalls issue while a load's destination register is still pending.
- Outputs drive the register file's RegWrite / w_reg_addr / w_data directly.

Parameters:
- LSU_FIFO_DEPTH, 2, load-return buffer entries (power of 2, ≥2).
- STARVE_LIMIT, 8, counter width basis for the optional perf counter saturation (2^STARVE_LIMIT − 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- alu_wb_valid  input  1  ALU result valid this cycle; always accepted, no ready.
- alu_wb_addr  input  5  ALU destination register.
- alu_wb_data  input  32  ALU result.
- lsu_wb_valid  input  1  load data return valid.
- lsu_wb_ready  output  1  FIFO not full.
- lsu_wb_addr  input  5  load destination register.
- lsu_wb_data  input  32  load data.
- issue_valid  input  1  instruction presented for issue.
- issue_is_load  input  1  presented instruction is a load.
- issue_rs1_addr  input  5  source register 1.
- issue_rs2_addr  input  5  source register 2.
- issue_rd_addr  input  5  destination register.
- issue_stall  output  1  hold issue this cycle.
- RegWrite  output  1  register-file write enable.
- w_reg_addr  output  32  write address, zero-extended from 5 bits.
- w_data  output  32  write data.

Behaviour:
- Reset (reset=0, async) clears:
  - RegWrite=0, w_reg_addr=0, w_data=0.
  - FIFO emptied; lsu_wb_ready=1 once reset deasserts.
  - pending[31:0]=0; issue_stall=0.
  - Reset mid-operation drops all buffered loads.
- Load enqueue: the LSU entry is enqueued when lsu_wb_valid && lsu_wb_ready. The head becomes visible the next cycle. There is no bypass.
- Grant, one per cycle:
  - If alu_wb_valid, the ALU wins.
  - Else, if the FIFO is non-empty, the head is dequeued.
- Write stage is registered:
  - ALU: valid at N gives RegWrite at N+1.
  - LSU: accepted at N, with no ALU traffic, gives RegWrite at N+2.
- x0 writes: address 0 never raises RegWrite. An LSU entry for x0 is still dequeued.
- Full/empty:
  - A full FIFO drops lsu_wb_ready in the same cycle.
  - A dequeue and an enqueue on a full FIFO in the same cycle: ready stays 0 that cycle, because it is based on registered count.
  - Pointers wrap modulo LSU_FIFO_DEPTH.
- Scoreboard set: pending[rd] is set when issue_valid && issue_is_load && !issue_stall && rd!=0.
- Scoreboard clear: pending[addr] is cleared on the cycle the registered write stage holds an LSU write (RegWrite=1, internal wb_is_load=1).
  - If a set and a clear hit the same register in the same cycle, set wins.
- issue_stall (combinational) is asserted when issue_valid and any of the following is true for a non-zero register:
  - pending[rs1]
  - pending[rs2]
  - pending[rd]
- issue_stall deasserts the cycle after the load's RegWrite, so the register-file read sees the new value.

Optional Feature:
- Macro RF_WB_PERF_EN.
- When defined:
  - Adds output alu_conflict_cnt, width STARVE_LIMIT, saturating.
  - It increments each cycle the FIFO is non-empty and the ALU takes the port.
  - It is cleared by reset.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package rf_pkg:
  - REG_ADDR_W=5, XLEN=32.
  - typedef wb_req_t {addr, data}.
  - localparam ZERO_REG=0.
- Sub-module wb_fifo (parameterised depth, push/pop/full/empty/count) holds the load-return buffer. Arbitration, write stage and scoreboard stay in the top.

Test Plan:
- ALU only: alu_wb_valid=1, addr=5, data=0xDEADBEEF at N -> RegWrite=1, w_reg_addr=5, w_data=0xDEADBEEF at N+1.
- Conflict: ALU (3,0x11) and LSU (4,0x22) both valid at N, ALU idle after -> writes (3,0x11) at N+1, then (4,0x22) at N+2.
- Full FIFO: ALU valid continuously and 2 LSU returns -> lsu_wb_ready=0 after the 2nd. Drop the ALU -> both loads written in order on consecutive cycles, then ready=1.
- Scoreboard: load with rd=7 issued, then an instruction with rs1=7 -> issue_stall=1 until the cycle after the RegWrite of addr 7; rs1=0 never stalls.
- x0: ALU and LSU writes to addr 0 -> RegWrite stays 0; the FIFO still drains; no pending bit is set.
- Reset mid-operation: 2 loads buffered, pending[9]=1, reset pulsed low -> FIFO empty, pending cleared, RegWrite=0, no stale write after release.
